count_seq: RTL and testbench

Sequencer and arbiter for the 4-bit up/down counter datapath. Drives the counter's `enable`/`updn`/`reset` controls from two sources: single-step requests from two competing requesters (round-robin arbitrated), and an autonomous triangle sweep mode (0 → HI → 0, repeated PASSES times). Keeps a shadow position equal to the counter value, so decisions never depend on counter read-back latency.

---
 rtl/count_seq.sv | 177 +++++++++++++++++
 tb/tb_count_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq.sv
// count_seq: sequencer/arbiter for a 4-bit up/down counter.
// Serves single-step requests (round-robin between up and down requesters)
// and runs an autonomous 0 -> HI -> 0 triangle sweep repeated PASSES times.
// A shadow position tracks the counter so decisions never wait on read-back.
// Optional feature macro: COUNT_SEQ_DWELL_EN adds a one-cycle hold (DWELL) at
// each HI turnaround and at 0 between passes.
module count_seq #(
    parameter int WIDTH  = 4,
    parameter int HI     = 15,
    parameter int PASSES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             req_up,
    input  logic             req_dn,
    output logic             gnt_up,
    output logic             gnt_dn,
    output logic             sat,
    output logic             cnt_en,
    output logic             cnt_updn,
    output logic             cnt_rst,
    output logic [WIDTH-1:0] pos,
    output logic             busy,
    output logic             done
);

`ifdef COUNT_SEQ_DWELL_EN
    typedef enum logic [2:0] {IDLE, CLEAR, UP, DOWN, DWELL} state_t;
`else
    typedef enum logic [1:0] {IDLE, CLEAR, UP, DOWN} state_t;
`endif

    localparam int             PW    = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [PW-1:0]  LAST  = PW'(PASSES - 1);
    localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

    state_t           state, state_n;
    logic [PW-1:0]    pass_cnt, pass_n;
    logic             last_b, last_b_n;   // 1: B was granted last, so A wins a tie
    logic             en_n, updn_n, rst_n, gup_n, gdn_n, sat_n, done_n;
    logic [WIDTH-1:0] pos_eff;

    // Position after the current edge: the step (or clear) being issued this
    // cycle lands on the coming edge, so limits are judged against it.
    always_comb begin
        pos_eff = pos;
        if (cnt_rst)
            pos_eff = '0;
        else if (cnt_en)
            pos_eff = cnt_updn ? pos + 1'b1 : pos - 1'b1;
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_n  = state;
        pass_n   = pass_cnt;
        last_b_n = last_b;
        en_n     = 1'b0;
        updn_n   = 1'b1;
        rst_n    = 1'b0;
        gup_n    = 1'b0;
        gdn_n    = 1'b0;
        sat_n    = 1'b0;
        done_n   = 1'b0;
        if (stop) begin
            state_n = IDLE;
            pass_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = CLEAR;
                        rst_n   = 1'b1;
                    end else if (req_up && (!req_dn || last_b)) begin
                        gup_n    = 1'b1;
                        last_b_n = 1'b0;
                        if (pos_eff < HI_V) en_n = 1'b1;
                        else                sat_n = 1'b1;
                    end else if (req_dn) begin
                        gdn_n    = 1'b1;
                        last_b_n = 1'b1;
                        if (pos_eff != '0) begin
                            en_n   = 1'b1;
                            updn_n = 1'b0;
                        end else begin
                            sat_n = 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state_n = UP;
                    en_n    = 1'b1;
                end
                UP: begin
                    if (pos_eff == HI_V) begin
`ifdef COUNT_SEQ_DWELL_EN
                        state_n = DWELL;
`else
                        state_n = DOWN;
                        en_n    = 1'b1;
                        updn_n  = 1'b0;
`endif
                    end else begin
                        en_n = 1'b1;
                    end
                end
`ifdef COUNT_SEQ_DWELL_EN
                DWELL: begin
                    // Turnaround direction follows from where the hold happened.
                    en_n = 1'b1;
                    if (pos_eff == HI_V) begin
                        state_n = DOWN;
                        updn_n  = 1'b0;
                    end else begin
                        state_n = UP;
                    end
                end
`endif
                DOWN: begin
                    if (pos_eff == '0) begin
                        if (pass_cnt == LAST) begin
                            state_n = IDLE;
                            pass_n  = '0;
                            done_n  = 1'b1;
                        end else begin
                            pass_n = pass_cnt + 1'b1;
`ifdef COUNT_SEQ_DWELL_EN
                            state_n = DWELL;
`else
                            state_n = UP;
                            en_n    = 1'b1;
`endif
                        end
                    end else begin
                        en_n   = 1'b1;
                        updn_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, shadow position and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pos      <= '0;
            pass_cnt <= '0;
            last_b   <= 1'b1;
            cnt_en   <= 1'b0;
            cnt_updn <= 1'b1;
            cnt_rst  <= 1'b1;
            gnt_up   <= 1'b0;
            gnt_dn   <= 1'b0;
            sat      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            pos      <= pos_eff;
            pass_cnt <= pass_n;
            last_b   <= last_b_n;
            cnt_en   <= en_n;
            cnt_updn <= updn_n;
            cnt_rst  <= rst_n;
            gnt_up   <= gup_n;
            gnt_dn   <= gdn_n;
            sat      <= sat_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_count_seq.sv
// Self-checking bench for count_seq: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// plan-based behavioural model.
module tb_count_seq;
    localparam int W = 4, HI = 5, PASSES = 2;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
    logic req_up = 1'b0, req_dn = 1'b0;
    logic gnt_up, gnt_dn, sat, cnt_en, cnt_updn, cnt_rst, busy, done;
    logic [W-1:0] pos;

    always #5 clk = ~clk;

    count_seq #(.WIDTH(W), .HI(HI), .PASSES(PASSES)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .req_up(req_up), .req_dn(req_dn), .gnt_up(gnt_up), .gnt_dn(gnt_dn),
        .sat(sat), .cnt_en(cnt_en), .cnt_updn(cnt_updn), .cnt_rst(cnt_rst),
        .pos(pos), .busy(busy), .done(done)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A sweep is a list of per-cycle actions: 0 clear, 1 up, 2 down, 3 hold.
    bit e_en, e_updn = 1, e_rst = 1, e_gup, e_gdn, e_sat, e_busy, e_done;
    int m_pos = 0;
    bit m_last_b = 1;
    bit started = 0;
    int plan[$];

    task automatic apply(int a);
        case (a)
            0: e_rst = 1;
            1: begin e_en = 1; e_updn = 1; end
            2: begin e_en = 1; e_updn = 0; end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        int np;
        np = e_rst ? 0 : (e_en ? (e_updn ? m_pos + 1 : m_pos - 1) : m_pos);
        e_en = 0; e_updn = 1; e_rst = 0; e_gup = 0; e_gdn = 0; e_sat = 0; e_done = 0;
        if (reset) begin
            plan.delete();
            e_busy = 0; e_rst = 1; m_last_b = 1; np = 0;
        end else if (e_busy) begin
            if (stop) begin
                e_busy = 0; plan.delete();
            end else if (plan.size() == 0) begin
                e_busy = 0; e_done = 1;
            end else begin
                apply(plan.pop_front());
            end
        end else if (stop) begin
        end else if (start) begin
            plan.push_back(0);
            for (int p = 0; p < PASSES; p++) begin
                for (int i = 0; i < HI; i++) plan.push_back(1);
`ifdef COUNT_SEQ_DWELL_EN
                plan.push_back(3);
`endif
                for (int i = 0; i < HI; i++) plan.push_back(2);
`ifdef COUNT_SEQ_DWELL_EN
                if (p < PASSES - 1) plan.push_back(3);
`endif
            end
            apply(plan.pop_front());
            e_busy = 1;
        end else if (req_up && (!req_dn || m_last_b)) begin
            e_gup = 1; m_last_b = 0;
            if (np < HI) begin e_en = 1; e_updn = 1; end else e_sat = 1;
        end else if (req_dn) begin
            e_gdn = 1; m_last_b = 1;
            if (np > 0) begin e_en = 1; e_updn = 0; end else e_sat = 1;
        end
        m_pos = np;
        started = 1;
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("gnt_up",   32'(gnt_up),   32'(e_gup));
            check("gnt_dn",   32'(gnt_dn),   32'(e_gdn));
            check("sat",      32'(sat),      32'(e_sat));
            check("cnt_en",   32'(cnt_en),   32'(e_en));
            check("cnt_updn", 32'(cnt_updn), 32'(e_updn));
            check("cnt_rst",  32'(cnt_rst),  32'(e_rst));
            check("busy",     32'(busy),     32'(e_busy));
            check("done",     32'(done),     32'(e_done));
            check("pos",      32'(pos),      32'(m_pos));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wait_step(int target, bit up, string name);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (busy && cnt_en && cnt_updn == up && 32'(pos) == target) found = 1;
            else tick();
        end
        check(name, 32'(found), 32'd1);
    endtask

`ifdef COUNT_SEQ_DWELL_EN
    localparam int NF = 24;
`else
    localparam int NF = 21;
`endif

    initial begin
        logic [1:0] gseq [4];
        int pv [NF + 2];
        bit dv [NF + 2];
        bit seen;

        // reset values
        reset = 1;
        repeat (2) tick();
        check("rst_cnt_rst", 32'(cnt_rst), 32'd1);
        check("rst_cnt_en",  32'(cnt_en),  32'd0);
        check("rst_pos",     32'(pos),     32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_gnt",     32'({gnt_up, gnt_dn}), 32'd0);
        reset = 0;
        tick();

        // stop mid-sweep with pos landing on 3
        start = 1; tick(); start = 0;
        wait_step(2, 1'b1, "wait_up2");
        stop = 1; tick(); stop = 0;
        check("stop_pos",  32'(pos),    32'd3);
        check("stop_busy", 32'(busy),   32'd0);
        check("stop_done", 32'(done),   32'd0);
        check("stop_en",   32'(cnt_en), 32'd0);
        tick();
        check("stop_hold", 32'(pos), 32'd3);

        // round robin from pos 3: A first after reset
        req_up = 1; req_dn = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            gseq[i] = {gnt_up, gnt_dn};
        end
        req_up = 0; req_dn = 0;
        tick(); tick();
        check("rr_g0", 32'(gseq[0]), 32'd2);
        check("rr_g1", 32'(gseq[1]), 32'd1);
        check("rr_g2", 32'(gseq[2]), 32'd2);
        check("rr_g3", 32'(gseq[3]), 32'd1);
        check("rr_pos", 32'(pos), 32'd3);

        // saturation at HI
        req_up = 1; tick(); tick(); req_up = 0;
        tick(); tick();
        check("up_pos5", 32'(pos), 32'd5);
        req_up = 1; tick();
        check("sat_hi_gnt", 32'(gnt_up), 32'd1);
        check("sat_hi_sat", 32'(sat),    32'd1);
        check("sat_hi_en",  32'(cnt_en), 32'd0);
        req_up = 0; tick(); tick();
        check("sat_hi_pos", 32'(pos), 32'd5);

        // saturation at 0
        req_dn = 1; repeat (5) tick(); req_dn = 0;
        tick(); tick();
        check("dn_pos0", 32'(pos), 32'd0);
        req_dn = 1; tick();
        check("sat_lo_gnt", 32'(gnt_dn), 32'd1);
        check("sat_lo_sat", 32'(sat),    32'd1);
        check("sat_lo_en",  32'(cnt_en), 32'd0);
        req_dn = 0; tick();
        check("sat_lo_pos", 32'(pos), 32'd0);

        // full sweep, pos observed after each edge E1..
        start = 1; tick(); start = 0;
        for (int k = 1; k <= NF + 1; k++) begin
            tick();
            pv[k] = 32'(pos);
            dv[k] = done;
        end
        check("sw_e1",  32'(pv[1]), 32'd0);
        check("sw_e6",  32'(pv[6]), 32'd5);
`ifdef COUNT_SEQ_DWELL_EN
        check("sw_e7",  32'(pv[7]),  32'd5);
        check("sw_e12", 32'(pv[12]), 32'd0);
        check("sw_e13", 32'(pv[13]), 32'd0);
        check("sw_e18", 32'(pv[18]), 32'd5);
`else
        check("sw_e7",  32'(pv[7]),  32'd4);
        check("sw_e11", 32'(pv[11]), 32'd0);
        check("sw_e12", 32'(pv[12]), 32'd1);
        check("sw_e16", 32'(pv[16]), 32'd5);
`endif
        check("sw_end",     32'(pv[NF]),   32'd0);
        check("sw_done",    32'(dv[NF]),   32'd1);
        check("sw_nodone",  32'(dv[NF-1]), 32'd0);
        check("sw_done1",   32'(dv[NF+1]), 32'd0);

        // reset mid-sweep in DOWN at pos 2
        start = 1; tick(); start = 0;
        wait_step(2, 1'b0, "wait_dn2");
        reset = 1; tick(); reset = 0;
        check("mrst_pos",  32'(pos),     32'd0);
        check("mrst_busy", 32'(busy),    32'd0);
        check("mrst_rst",  32'(cnt_rst), 32'd1);
        tick();
        start = 1; tick(); start = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("mrst_sweep_done", 32'(seen), 32'd1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset  = ($urandom_range(0, 499) == 0);
            start  = ($urandom_range(0, 15) == 0);
            stop   = ($urandom_range(0, 39) == 0);
            req_up = ($urandom_range(0, 2) != 0);
            req_dn = ($urandom_range(0, 2) != 0);
            if (stop) begin req_up = 0; req_dn = 0; end
            tick();
        end
        reset = 0; start = 0; stop = 0; req_up = 0; req_dn = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
